// File: rtl/edram_pkg.sv
// edram_pkg: shared types and helpers for the eDRAM bank.
//   ecc_bits(data_w)  -> SECDED check-bit count (Hamming bits + overall parity)
//   data_pos(idx)     -> Hamming position of data bit idx (non-power-of-two slots from 3)
//   state_e           -> operation sequencer states
//   EDRAM_CW_W(dw)    -> stored codeword width for dw data bits
`ifndef EDRAM_PKG_SV
`define EDRAM_PKG_SV

`define EDRAM_CW_W(dw) ((dw) + edram_pkg::ecc_bits(dw))

package edram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACT  = 2'd1,
    ST_DEC  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Smallest r with 2^r >= data_w + r + 1, plus one overall-parity bit.
  function automatic int unsigned ecc_bits(input int unsigned data_w);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < (data_w + r + 1)) r++;
    return r + 1;
  endfunction

  // Data bits occupy the Hamming positions that are not powers of two.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 3; p < (2 * idx + 8); p++) begin
      if (((p & (p - 1)) != 0) && (pos == 0)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

`endif

// File: rtl/edram_secded.sv
// edram_secded: combinational extended-Hamming SECDED.
//   data_i   -> cw_o      encode: {overall parity, check bits, data}
//   cw_i     -> flip_o    bit mask that repairs a single-bit error (zero otherwise)
//            -> corr_o    single-bit error found
//            -> uncorr_o  double-bit (uncorrectable) error found
module edram_secded
  import edram_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0]              data_i,
  output logic [`EDRAM_CW_W(DATA_W)-1:0] cw_o,
  input  logic [`EDRAM_CW_W(DATA_W)-1:0] cw_i,
  output logic [`EDRAM_CW_W(DATA_W)-1:0] flip_o,
  output logic                           corr_o,
  output logic                           uncorr_o
);

  localparam int unsigned ECC_W = ecc_bits(DATA_W);
  localparam int unsigned R     = ECC_W - 1;
  localparam int unsigned CW_W  = DATA_W + ECC_W;

  // Data bits covered by Hamming check bit j.
  function automatic logic [DATA_W-1:0] chk_mask(input int unsigned j);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (((data_pos(i) >> j) & 32'd1) != 0) m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [R-1:0]      chk_enc;
  logic [R-1:0]      chk_dec;
  logic [R-1:0]      syn;
  logic [R-1:0]      cflip;
  logic [DATA_W-1:0] dflip;
  logic              pflip;
  logic              par;
  logic              hit;

  for (genvar j = 0; j < R; j++) begin : g_chk
    localparam logic [DATA_W-1:0] MASK = chk_mask(j);
    assign chk_enc[j] = ^(data_i & MASK);
    assign chk_dec[j] = ^(cw_i[DATA_W-1:0] & MASK);
    assign cflip[j]   = (syn == R'(32'd1 << j));
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_dflip
    localparam int unsigned POS = data_pos(i);
    assign dflip[i] = (syn == R'(POS));
  end

  assign cw_o = {^{chk_enc, data_i}, chk_enc, data_i};

  // Odd overall parity means one flipped bit; syndrome 0 then points at the parity bit.
  assign syn    = chk_dec ^ cw_i[DATA_W +: R];
  assign par    = ^cw_i;
  assign pflip  = (syn == '0);
  assign hit    = |{pflip, cflip, dflip};

  assign flip_o   = par ? CW_W'({pflip, cflip, dflip}) : '0;
  assign corr_o   = par & hit;
  // Odd parity with a syndrome pointing nowhere is an odd multi-bit error.
  assign uncorr_o = par ? ~hit : (syn != '0);

endmodule

// File: rtl/edram_bank.sv
// edram_bank: single-port eDRAM bank with SECDED, read writeback and refresh/scrub.
//   clk, rst           clock, synchronous active-high reset
//   req_*              valid/ready request port (we, addr, wdata); inj_flip XORs into write codeword
//   rd_valid/rd_data   one-cycle read return with corrected data
//   err_corr/uncorr    error flags with rd_valid
//   corr_cnt           saturating corrected-error count (reads and refresh)
//   ref_busy           refresh operation in flight
module edram_bank
  import edram_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned REF_INTERVAL = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [DATA_W-1:0]              req_wdata,
  input  logic [`EDRAM_CW_W(DATA_W)-1:0] inj_flip,
  output logic                           rd_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           err_corr,
  output logic                           err_uncorr,
  output logic [15:0]                    corr_cnt,
  output logic                           ref_busy
);

  localparam int unsigned ECC_W = ecc_bits(DATA_W);
  localparam int unsigned CW_W  = DATA_W + ECC_W;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TMR_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CW_W-1:0] mem [0:DEPTH-1];

  state_e            state_q, state_d;
  logic              op_we_q, op_we_d;
  logic              op_ref_q, op_ref_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW_W-1:0]   inj_q, inj_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic [CW_W-1:0]   flip_q, flip_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              ref_pend_q, ref_pend_d;
  logic [ADDR_W-1:0] ref_ptr_q, ref_ptr_d;
  logic [15:0]       corr_cnt_q, corr_cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_corr_q, err_corr_d;
  logic              err_uncorr_q, err_uncorr_d;
  logic              ref_busy_q, ref_busy_d;
  logic              mem_we_c;

  logic [CW_W-1:0]   enc_cw;
  logic [CW_W-1:0]   dec_flip;
  logic              dec_corr;
  logic              dec_uncorr;
  logic [CW_W-1:0]   enc_unused_flip;
  logic              enc_unused_corr;
  logic              enc_unused_uncorr;
  logic [CW_W-1:0]   dec_unused_cw;

  // Write-path encoder.
  edram_secded #(.DATA_W(DATA_W)) u_enc (
    .data_i   (wdata_q),
    .cw_o     (enc_cw),
    .cw_i     ('0),
    .flip_o   (enc_unused_flip),
    .corr_o   (enc_unused_corr),
    .uncorr_o (enc_unused_uncorr)
  );

  // Read-path syndrome decoder on the activated codeword.
  edram_secded #(.DATA_W(DATA_W)) u_dec (
    .data_i   ('0),
    .cw_o     (dec_unused_cw),
    .cw_i     (cw_q),
    .flip_o   (dec_flip),
    .corr_o   (dec_corr),
    .uncorr_o (dec_uncorr)
  );

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    op_we_d      = op_we_q;
    op_ref_d     = op_ref_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inj_d        = inj_q;
    cw_d         = cw_q;
    flip_d       = flip_q;
    ref_pend_d   = ref_pend_q;
    ref_ptr_d    = ref_ptr_q;
    corr_cnt_d   = corr_cnt_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    err_corr_d   = 1'b0;
    err_uncorr_d = 1'b0;
    mem_we_c     = 1'b0;
    timer_d      = (timer_q == TMR_W'(REF_INTERVAL - 1)) ? '0 : timer_q + TMR_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (ref_pend_q) begin
          state_d    = ST_ACT;
          op_ref_d   = 1'b1;
          op_we_d    = 1'b0;
          addr_d     = ref_ptr_q;
          ref_pend_d = 1'b0;
        end else if (req_valid && req_ready) begin
          state_d  = ST_ACT;
          op_ref_d = 1'b0;
          op_we_d  = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          inj_d    = inj_flip;
        end
      end
      ST_ACT: begin
        state_d = ST_DEC;
        cw_d    = op_we_q ? (enc_cw ^ inj_q) : mem[addr_q];
      end
      ST_DEC: begin
        state_d = ST_WB;
        if (op_we_q) begin
          flip_d = '0;
        end else begin
          // Uncorrectable words get a zero mask, so raw data is returned and written back.
          flip_d = dec_flip;
          if (dec_corr && (corr_cnt_q != 16'hFFFF)) corr_cnt_d = corr_cnt_q + 16'd1;
          if (!op_ref_q) begin
            rd_valid_d   = 1'b1;
            rd_data_d    = cw_q[DATA_W-1:0] ^ dec_flip[DATA_W-1:0];
            err_corr_d   = dec_corr;
            err_uncorr_d = dec_uncorr;
          end
        end
      end
      ST_WB: begin
        state_d  = ST_IDLE;
        mem_we_c = 1'b1;
        if (op_ref_q) ref_ptr_d = ref_ptr_q + ADDR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // A timer wrap while already pending just keeps the single pending flag set.
    if (timer_q == TMR_W'(REF_INTERVAL - 1)) ref_pend_d = 1'b1;

    req_ready_d = (state_d == ST_IDLE) && !ref_pend_d;
    ref_busy_d  = (state_d != ST_IDLE) && op_ref_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_we_q      <= 1'b0;
      op_ref_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inj_q        <= '0;
      cw_q         <= '0;
      flip_q       <= '0;
      timer_q      <= '0;
      ref_pend_q   <= 1'b0;
      ref_ptr_q    <= '0;
      corr_cnt_q   <= '0;
      req_ready_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
      ref_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_we_q      <= op_we_d;
      op_ref_q     <= op_ref_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inj_q        <= inj_d;
      cw_q         <= cw_d;
      flip_q       <= flip_d;
      timer_q      <= timer_d;
      ref_pend_q   <= ref_pend_d;
      ref_ptr_q    <= ref_ptr_d;
      corr_cnt_q   <= corr_cnt_d;
      req_ready_q  <= req_ready_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      err_corr_q   <= err_corr_d;
      err_uncorr_q <= err_uncorr_d;
      ref_busy_q   <= ref_busy_d;
    end
  end

  // Array write port; a reset during WB suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_c) mem[addr_q] <= cw_q ^ flip_q;
  end

  assign req_ready  = req_ready_q & ~rst;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign err_corr   = err_corr_q;
  assign err_uncorr = err_uncorr_q;
  assign corr_cnt   = corr_cnt_q;
  assign ref_busy   = ref_busy_q;

endmodule

// File: tb/tb_edram_bank.sv
// tb_edram_bank: directed checks of edram_bank (64-bit data, 32 rows, refresh every 8 clocks).
module tb_edram_bank;
  import edram_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [63:0] req_wdata;
  logic [71:0] inj_flip;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        err_corr;
  logic        err_uncorr;
  logic [15:0] corr_cnt;
  logic        ref_busy;

  int n_tot = 0;
  int n_bad = 0;
  int last_wait = 0;

  edram_bank #(.DATA_W(64), .ADDR_W(5), .REF_INTERVAL(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .inj_flip   (inj_flip),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .corr_cnt   (corr_cnt),
    .ref_busy   (ref_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] init_val(input int a);
    return 64'hC0DE_0000_0000_0000 | (64'(a) << 8) | 64'(a);
  endfunction

  // Hold a request until accepted; returns #1 into cycle T+1.
  task automatic issue(input logic we, input logic [4:0] a, input logic [63:0] dat,
                       input logic [71:0] inj);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = dat;
    inj_flip  = inj;
    while (req_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) chk("ready_timeout", 64'(req_ready), 64'd1);
    last_wait = n;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    inj_flip  = '0;
  endtask

  // Write; returns #1 into the WB cycle.
  task automatic wr(input logic [4:0] a, input logic [63:0] dat, input logic [71:0] inj);
    issue(1'b1, a, dat, inj);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wr_no_rd_valid", 64'(rd_valid), 64'd0);
  endtask

  // Read with pulse timing checks; returns #1 into cycle T+4.
  task automatic rd(input string tag, input logic [4:0] a, output logic [63:0] d,
                    output logic c, output logic u);
    issue(1'b0, a, 64'd0, 72'd0);
    @(posedge clk); #1;
    chk({tag, "_rv_t2"}, 64'(rd_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_rv_t3"}, 64'(rd_valid), 64'd1);
    d = rd_data;
    c = err_corr;
    u = err_uncorr;
    @(posedge clk); #1;
    chk({tag, "_rv_t4"}, 64'(rd_valid), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic        c;
    logic        u;
    int          k;
    int          last_rise;
    int          viol_rdy;
    int          viol_rv;
    int          n_rv;
    int          bad_data;
    int          nb;
    int          n;
    logic        prev_busy;
    logic        seen;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    inj_flip  = '0;

    // Give every row a clean codeword; reset does not clear the array.
    do_reset();
    for (int a = 0; a < 32; a++) wr(5'(a), init_val(a), 72'd0);

    // Reset values while rst is held.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_err", 64'({err_corr, err_uncorr}), 64'd0);
    chk("rst_ref_busy", 64'(ref_busy), 64'd0);
    chk("rst_corr_cnt", 64'(corr_cnt), 64'd0);
    chk("rst_ref_ptr", 64'(dut.ref_ptr_q), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // Write then back-to-back read of addr 3.
    wr(5'd3, 64'h0123_4567_89AB_CDEF, 72'd0);
    rd("t1", 5'd3, d, c, u);
    chk("t1_b2b_wait", 64'(last_wait), 64'd1);
    chk("t1_data", d, 64'h0123_4567_89AB_CDEF);
    chk("t1_err", 64'({c, u}), 64'd0);

    // Single-bit injection at addr 7, repaired by the first read's writeback.
    do_reset();
    wr(5'd7, 64'hFEDC_BA98_7654_3210, 72'h20);
    rd("t2a", 5'd7, d, c, u);
    chk("t2a_data", d, 64'hFEDC_BA98_7654_3210);
    chk("t2a_corr", 64'(c), 64'd1);
    chk("t2a_uncorr", 64'(u), 64'd0);
    chk("t2a_cnt", 64'(corr_cnt), 64'd1);
    rd("t2b", 5'd7, d, c, u);
    chk("t2b_data", d, 64'hFEDC_BA98_7654_3210);
    chk("t2b_corr", 64'(c), 64'd0);
    chk("t2b_cnt", 64'(corr_cnt), 64'd1);

    // Double-bit injection at addr 9: raw data returned, error persists.
    do_reset();
    wr(5'd9, 64'h0F0F_F0F0_3C3C_C3C3, 72'h3);
    rd("t3a", 5'd9, d, c, u);
    chk("t3a_uncorr", 64'(u), 64'd1);
    chk("t3a_corr", 64'(c), 64'd0);
    chk("t3a_data_raw", d, 64'h0F0F_F0F0_3C3C_C3C0);
    chk("t3a_cnt", 64'(corr_cnt), 64'd0);
    rd("t3b", 5'd9, d, c, u);
    chk("t3b_uncorr", 64'(u), 64'd1);
    chk("t3b_cnt", 64'(corr_cnt), 64'd0);

    // Refresh sweep with reads held on addr 3.
    do_reset();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'd3;
    prev_busy = 1'b0;
    k = 0; last_rise = 0; viol_rdy = 0; viol_rv = 0; n_rv = 0; bad_data = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (ref_busy && !prev_busy) begin
        chk("sweep_ptr", 64'(dut.ref_ptr_q), 64'(k % 32));
        if (k > 0) chk("sweep_gap", 64'(i - last_rise), 64'd8);
        last_rise = i;
        k++;
      end
      if (ref_busy && req_ready) viol_rdy++;
      if (ref_busy && rd_valid) viol_rv++;
      if (rd_valid) begin
        n_rv++;
        if (rd_data !== 64'h0123_4567_89AB_CDEF) bad_data++;
      end
      prev_busy = ref_busy;
    end
    req_valid = 1'b0;
    chk("sweep_refreshes", 64'(k), 64'd37);
    chk("sweep_ready_in_ref", 64'(viol_rdy), 64'd0);
    chk("sweep_rv_in_ref", 64'(viol_rv), 64'd0);
    chk("sweep_rv_seen", 64'(n_rv >= 30), 64'd1);
    chk("sweep_rd_data", 64'(bad_data), 64'd0);
    chk("sweep_cnt", 64'(corr_cnt), 64'd0);

    // Scrub of a single-bit error at addr 0 without user reads.
    do_reset();
    wr(5'd0, 64'hAAAA_5555_0000_FFFF, 72'h20);
    seen = 1'b0; nb = 0; n = 0;
    while (!(seen && !ref_busy) && n < 40) begin
      if (ref_busy) begin
        seen = 1'b1;
        nb++;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("scrub_seen", 64'(seen), 64'd1);
    chk("scrub_busy_len", 64'(nb), 64'd3);
    chk("scrub_cnt", 64'(corr_cnt), 64'd1);
    rd("t5", 5'd0, d, c, u);
    chk("t5_data", d, 64'hAAAA_5555_0000_FFFF);
    chk("t5_corr", 64'(c), 64'd0);

    // Reset during DEC of a write to addr 4 aborts it.
    do_reset();
    issue(1'b1, 5'd4, 64'hDEAD_BEEF_DEAD_BEEF, 72'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("abort_rd_valid", 64'(rd_valid), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd0);
    chk("abort_ref_busy", 64'(ref_busy), 64'd0);
    chk("abort_cnt", 64'(corr_cnt), 64'd0);
    chk("abort_rd_data", rd_data, 64'd0);
    rst = 1'b0;
    rd("t6", 5'd4, d, c, u);
    chk("t6_data", d, init_val(4));
    chk("t6_err", 64'({c, u}), 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/edram_bank.md
# edram_bank

Parametrised single-port eDRAM bank with SECDED ECC, destructive-read writeback and an internal refresh/scrub engine. It is the generalised successor of the fixed 32x325 eDRAM macro, with configurable width, depth and refresh interval, a valid/ready request port, and error reporting. It sits between a cache or tag controller and the raw array, and hides refresh, ECC and writeback from the requester.

## Interface
- `DATA_W`, 64: user data bits per word.
- `ADDR_W`, 5: address bits; depth is `1<<ADDR_W`.
- `REF_INTERVAL`, 64: clocks between refresh requests; must be at least 8.
- `clk`  in  1  the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when `req_valid & req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `inj_flip`  in  DATA_W+ECC_W  test hook; XORed into the encoded codeword on writes.
- `rd_valid`  out  1  one-cycle pulse, read data valid.
- `rd_data`  out  DATA_W  corrected read data.
- `err_corr`  out  1  pulses with `rd_valid` when a single-bit error was corrected.
- `err_uncorr`  out  1  pulses with `rd_valid` when a double-bit error was detected.
- `corr_cnt`  out  16  saturating count of corrected errors, including those found by refresh.
- `ref_busy`  out  1  a refresh operation is in flight.

## Operation
- `ECC_W` = r+1, where r is the smallest value with 2^r ≥ DATA_W+r+1. For DATA_W=64, ECC_W=8.
- Every operation takes exactly 4 cycles, sequenced by the FSM `IDLE → ACT → DEC → WB → IDLE`.
- `req_ready` = 1 only in `IDLE`, with no refresh pending and `rst` low.
- Read:
  - ACT: register the codeword from the array.
  - DEC: compute the syndrome, registered.
  - WB: write the corrected codeword back to the same row, and drive `rd_valid`, `rd_data`, `err_*`.
- Write:
  - ACT: encode `req_wdata`, then XOR with `inj_flip`.
  - DEC: hold.
  - WB: write the codeword. No `rd_valid`.
- Uncorrectable read: `rd_data` carries the raw data bits. WB writes back the raw codeword unchanged, so the error persists. `corr_cnt` is unchanged.
- Refresh timer:
  - Counts 0..REF_INTERVAL-1 and sets `ref_pend` on wrap.
  - In `IDLE`, `ref_pend` wins over `req_valid`.
  - A refresh runs the read sequence on row `ref_ptr` without `rd_valid`: the corrected word is written back and a corrected error increments `corr_cnt`.
  - Refresh clears `ref_pend` on entry and increments `ref_ptr` at WB, wrapping from 2^ADDR_W-1 to 0.
  - If the timer wraps again while `ref_pend` is still set, `ref_pend` stays 1 (no queueing).
- `corr_cnt` saturates at 0xFFFF.
- Reset values:
  - State `IDLE`; `req_ready`, `rd_valid`, `err_corr`, `err_uncorr`, `ref_busy` all 0.
  - `rd_data` = 0, `corr_cnt` = 0, `ref_ptr` = 0, timer = 0, `ref_pend` = 0.
  - Array contents are not cleared.
- Reset mid-operation aborts the operation without a WB write. A read aborted that way leaves its row's contents undefined; the requester must rewrite it.

## Timing
- Request accepted at cycle T.
- Read: `rd_valid` at T+3. The next request can be accepted at T+4.
- Throughput: one operation per 4 clocks.
- Refresh latency: the first `IDLE` cycle after `ref_pend` rises. `ref_busy` = 1 during ACT, DEC and WB of the refresh.
- Worst-case wait for `req_ready`: 3 cycles of an in-flight operation plus one 4-cycle refresh.
- Same-address write then read, back to back: the read at T+4 returns the written data, since the WB of the write has completed.

## Structure
- Package `edram_pkg`: `ecc_bits(DATA_W)` function, FSM state enum, codeword width macro.
- Sub-module `edram_secded`, parametrised by DATA_W:
  - combinational encode;
  - syndrome decode giving `corr`, `uncorr` and the flip mask.
  - The bank instantiates it once for encode and once for decode.
- Array: `reg [DATA_W+ECC_W-1:0] mem [0:2**ADDR_W-1]`, one read or write per cycle.

## Test plan
- Reset, then write 0x0123456789ABCDEF to addr 3 and read it back → `rd_valid` at T+3, data matches, `err_*` = 0.
- Write addr 7 with `inj_flip` bit 5 set, then read it twice → first read: correct data, `err_corr` = 1, `corr_cnt` = 1; second read: `err_corr` = 0 (writeback repaired the word).
- Write addr 9 with `inj_flip` bits 0 and 1 set, then read → `err_uncorr` = 1, `corr_cnt` = 0; a second read still gives `err_uncorr` = 1.
- REF_INTERVAL=8, `req_valid` held high with reads → one refresh every 8 clocks; `ref_ptr` visits 0..31 then wraps to 0; `req_ready` stays low during each refresh; no `rd_valid` from refresh.
- Single-bit error injected at addr 0, no user reads → after the refresh of row 0, `corr_cnt` = 1 and a later read gives `err_corr` = 0.
- Assert `rst` during DEC of a write to addr 4 → FSM in `IDLE` next cycle, no array write, all outputs at their reset values.
